// File: rtl/dmem_mmio.sv
// dmem_mmio
// Data-side memory and peripheral subsystem for the single-cycle core.
// Provides word-addressed RAM plus an MMIO region holding an LED register,
// a free-running cycle counter and a UART transmitter fed by a small FIFO.
//
// Ports:
//   clk        in   1   system clock, all state updates on the rising edge
//   reset      in   1   synchronous, active-high, overrides every write
//   addr       in  32   byte address from the core (addr[31] selects MMIO)
//   writedata  in  32   store data
//   memwrite   in   1   store strobe, sampled at the rising edge
//   readdata   out 32   load data, combinational from addr
//   leds       out  8   LED register
//   uart_tx    out  1   registered 8N1 serial output, LSB first, idle high
//
// MMIO map (offsets from 0x8000_0000, decoded on addr[7:2]):
//   0x00 LED     R/W   low byte drives leds
//   0x04 TXDATA  W     push a byte into the transmit FIFO (reads 0)
//   0x08 STATUS  R/W   {count[15:8], overflow[2], busy[1], full[0]}; write clears overflow
//   0x0C CYCLE   R     free-running cycle counter
module dmem_mmio #(
    parameter int RAM_WORDS    = 256,
    parameter int FIFO_DEPTH   = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic        uart_tx
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [PW:0]   FIFO_FULL_CNT = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CLK_LAST      = CW'(CLKS_PER_BIT - 1);

    localparam logic [5:0] OFF_LED    = 6'h00;
    localparam logic [5:0] OFF_TXDATA = 6'h01;
    localparam logic [5:0] OFF_STATUS = 6'h02;
    localparam logic [5:0] OFF_CYCLE  = 6'h03;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Storage
    logic [31:0]   ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [31:0]   cycle_count;

    // UART transmitter state
    uart_state_t   state;
    uart_state_t   state_next;
    logic [CW-1:0] clk_cnt;
    logic [CW-1:0] clk_cnt_next;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_next;
    logic [7:0]    shift;
    logic [7:0]    shift_next;
    logic          tx_next;
    logic          pop;

    // Address decode
    logic          is_mmio;
    logic [5:0]    offset;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          led_we;
    logic          tx_we;
    logic          status_we;
    logic          fifo_full;
    logic          push_ok;
    logic          busy;
    logic [7:0]    count8;

    // Address bits above the decoded fields alias by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[30:0]};

    assign is_mmio   = addr[31];
    assign offset    = addr[7:2];
    assign ram_idx   = addr[AW+1:2];
    assign ram_we    = memwrite && !is_mmio;
    assign led_we    = memwrite && is_mmio && (offset == OFF_LED);
    assign tx_we     = memwrite && is_mmio && (offset == OFF_TXDATA);
    assign status_we = memwrite && is_mmio && (offset == OFF_STATUS);

    // Fullness is judged on the pre-edge count, so a pop on the same edge
    // never makes room for a push into a full FIFO.
    assign fifo_full = (count == FIFO_FULL_CNT);
    assign push_ok   = tx_we && !fifo_full;
    assign busy      = (state != IDLE) || (count != '0);
    assign count8    = 8'(count);

    // Combinational load path so the core completes loads in one cycle.
    always_comb begin
        readdata = 32'h0;
        if (!is_mmio) begin
            readdata = ram[ram_idx];
        end else begin
            case (offset)
                OFF_LED:    readdata = {24'h0, leds};
                OFF_STATUS: readdata = {16'h0, count8, 5'b0, overflow, busy, fifo_full};
                OFF_CYCLE:  readdata = cycle_count;
                default:    readdata = 32'h0;
            endcase
        end
    end

    // RAM is deliberately not reset so its contents survive a core reset;
    // reset only blocks a store that coincides with it.
    always_ff @(posedge clk) begin
        if (!reset && ram_we) begin
            ram[ram_idx] <= writedata;
        end
    end

    // LED register, cycle counter and the sticky overflow flag. The overflow
    // set condition is tested first so a drop wins over a clear on one edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds        <= 8'h0;
            cycle_count <= 32'h0;
            overflow    <= 1'b0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (led_we) begin
                leds <= writedata[7:0];
            end
            if (tx_we && fifo_full) begin
                overflow <= 1'b1;
            end else if (status_we) begin
                overflow <= 1'b0;
            end
        end
    end

    // Transmit FIFO: circular buffer, pointers wrap naturally because the
    // depth is a power of two. A simultaneous push and pop leaves the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= writedata[7:0];
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // UART state register; uart_tx is registered from the next-state value
    // so the line changes on the same edge the FSM changes state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= 3'd0;
            shift   <= 8'h0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
            shift   <= shift_next;
            uart_tx <= tx_next;
        end
    end

    // UART next-state logic. IDLE always lasts at least one cycle because
    // the pop only happens while sitting in IDLE.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop          = 1'b1;
                    shift_next   = fifo_mem[rd_ptr];
                    clk_cnt_next = '0;
                    bit_cnt_next = 3'd0;
                    state_next   = START;
                end
            end
            START: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            STOP: begin
                if (clk_cnt == CLK_LAST) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    clk_cnt_next = clk_cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio
// Directed testbench for dmem_mmio: RAM, LED, CYCLE, UART framing, FIFO
// overflow, back-to-back frames and reset in the middle of a frame.
// A background receiver decodes uart_tx into a queue of {stop, data} bytes.
module tb_dmem_mmio;

    localparam int RAM_WORDS    = 256;
    localparam int FIFO_DEPTH   = 4;
    localparam int CLKS_PER_BIT = 16;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_TX     = 32'h8000_0004;
    localparam logic [31:0] A_STATUS = 32'h8000_0008;
    localparam logic [31:0] A_CYCLE  = 32'h8000_000C;
    localparam logic [31:0] A_NONE   = 32'h8000_0010;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic        memwrite = 1'b0;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic        uart_tx;

    int errors = 0;
    int checks = 0;
    int tb_cycle = 0;

    logic [8:0] rx_q[$];
    int         rx_start[$];
    int         rx_glitch = 0;

    dmem_mmio #(
        .RAM_WORDS(RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .writedata(writedata),
        .memwrite(memwrite),
        .readdata(readdata),
        .leds(leds),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cycle <= tb_cycle + 1;

    // Background UART receiver: samples each bit in its middle, records the
    // cycle the start bit was first seen plus {stop, data}.
    initial begin
        logic [7:0] b;
        logic       stop_bit;
        forever begin
            @(posedge clk); #1;
            if (uart_tx === 1'b0) begin
                rx_start.push_back(tb_cycle);
                repeat (CLKS_PER_BIT / 2) begin @(posedge clk); #1; end
                if (uart_tx !== 1'b0) rx_glitch++;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS_PER_BIT) begin @(posedge clk); #1; end
                    b[i] = uart_tx;
                end
                repeat (CLKS_PER_BIT) begin @(posedge clk); #1; end
                stop_bit = uart_tx;
                rx_q.push_back({stop_bit, b});
            end
        end
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        @(posedge clk); #1;
        memwrite  = 1'b0;
    endtask

    task automatic read_word(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = readdata;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (leds !== 8'h00) begin errors++; $display("[TB] FAIL reset_leds: got %h expected 00", leds); end
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_uart_tx: got %b expected 1", uart_tx); end
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00000000", d); end
        read_word(A_LED, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_led_read: got %h expected 00000000", d); end
        read_word(A_CYCLE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_cycle0: got %h expected 00000000", d); end
        tick();
        read_word(A_CYCLE, d);
        checks++; if (d !== 32'h1) begin errors++; $display("[TB] FAIL reset_cycle1: got %h expected 00000001", d); end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        write_word(32'h10, 32'hDEAD_BEEF);
        read_word(32'h10, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_read: got %h expected deadbeef", d); end
        read_word(32'h410, d);
        checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL ram_alias: got %h expected deadbeef", d); end
        write_word(32'h12, 32'h1234_5678);
        read_word(32'h10, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ram_byteoff: got %h expected 12345678", d); end
        write_word(32'h14, 32'hCAFE_F00D);
        read_word(32'h14, d);
        checks++; if (d !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL ram_next_word: got %h expected cafef00d", d); end
        read_word(32'h10, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("[TB] FAIL ram_neighbor: got %h expected 12345678", d); end
    endtask

    task automatic test_led();
        logic [31:0] d;
        write_word(A_LED, 32'h0000_01A5);
        checks++; if (leds !== 8'hA5) begin errors++; $display("[TB] FAIL led_out: got %h expected a5", leds); end
        read_word(A_LED, d);
        checks++; if (d !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL led_read: got %h expected 000000a5", d); end
        write_word(A_NONE, 32'hFFFF_FFFF);
        checks++; if (leds !== 8'hA5) begin errors++; $display("[TB] FAIL led_unmapped_write: got %h expected a5", leds); end
        read_word(A_NONE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL unmapped_read: got %h expected 00000000", d); end
        read_word(A_TX, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL txdata_read: got %h expected 00000000", d); end
        pulse_reset();
        checks++; if (leds !== 8'h00) begin errors++; $display("[TB] FAIL led_after_reset: got %h expected 00", leds); end
    endtask

    task automatic test_cycle();
        logic [31:0] a;
        logic [31:0] b;
        read_word(A_CYCLE, a);
        repeat (10) tick();
        read_word(A_CYCLE, b);
        checks++; if (b - a !== 32'd10) begin errors++; $display("[TB] FAIL cycle_delta: got %0d expected 10", b - a); end
        read_word(A_CYCLE, a);
        write_word(A_CYCLE, 32'h0);
        read_word(A_CYCLE, b);
        checks++; if (b !== a + 32'd1) begin errors++; $display("[TB] FAIL cycle_write_ignored: got %h expected %h", b, a + 32'd1); end
    endtask

    task automatic test_uart_single();
        logic [7:0]  byte_v;
        logic        exp;
        logic [31:0] d;
        byte_v = 8'h55;
        rx_q.delete();
        rx_start.delete();
        write_word(A_TX, {24'h0, byte_v});
        for (int k = 1; k <= 160; k++) begin
            tick();
            if (k <= 16)       exp = 1'b0;
            else if (k <= 144) exp = byte_v[(k - 17) / 16];
            else               exp = 1'b1;
            checks++; if (uart_tx !== exp) begin errors++; $display("[TB] FAIL uart_bit_k%0d: got %b expected %b", k, uart_tx, exp); end
            if (k == 80) begin
                read_word(A_STATUS, d);
                checks++; if (d !== 32'h2) begin errors++; $display("[TB] FAIL uart_status_busy: got %h expected 00000002", d); end
            end
        end
        tick();
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL uart_status_idle: got %h expected 00000000", d); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 9'h155) begin
            errors++; $display("[TB] FAIL uart_rx_single: got size %0d first %h expected size 1 first 155", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 9'h0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        int          waited;
        rx_q.delete();
        rx_start.delete();
        @(negedge clk);
        addr     = A_TX;
        memwrite = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            writedata = 32'(i);
            @(posedge clk); #1;
        end
        memwrite = 1'b0;
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h0000_0407) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 00000407", d); end
        waited = 0;
        while (rx_q.size() < 5 && waited < 1200) begin tick(); waited++; end
        checks++; if (rx_q.size() < 5) begin errors++; $display("[TB] FAIL ovf_frames_timeout: got %0d frames expected 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < rx_q.size()) begin
                checks++; if (rx_q[i] !== {1'b1, 8'(i + 1)}) begin errors++; $display("[TB] FAIL ovf_frame%0d: got %h expected %h", i, rx_q[i], {1'b1, 8'(i + 1)}); end
            end
        end
        repeat (200) tick();
        checks++; if (rx_q.size() != 5) begin errors++; $display("[TB] FAIL ovf_frame_count: got %0d expected 5", rx_q.size()); end
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h4) begin errors++; $display("[TB] FAIL ovf_sticky: got %h expected 00000004", d); end
        write_word(A_STATUS, 32'h0);
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL ovf_clear: got %h expected 00000000", d); end
    endtask

    task automatic test_back_to_back();
        int waited;
        rx_q.delete();
        rx_start.delete();
        write_word(A_TX, 32'hA3);
        write_word(A_TX, 32'h3C);
        waited = 0;
        while (rx_q.size() < 2 && waited < 600) begin tick(); waited++; end
        checks++; if (rx_q.size() < 2) begin
            errors++; $display("[TB] FAIL b2b_timeout: got %0d frames expected 2", rx_q.size());
        end else begin
            checks++; if (rx_q[0] !== 9'h1A3) begin errors++; $display("[TB] FAIL b2b_frame0: got %h expected 1a3", rx_q[0]); end
            checks++; if (rx_q[1] !== 9'h13C) begin errors++; $display("[TB] FAIL b2b_frame1: got %h expected 13c", rx_q[1]); end
            checks++; if (rx_start[1] - rx_start[0] != 161) begin errors++; $display("[TB] FAIL b2b_spacing: got %0d expected 161", rx_start[1] - rx_start[0]); end
        end
        checks++; if (rx_glitch != 0) begin errors++; $display("[TB] FAIL start_bit_glitch: got %0d expected 0", rx_glitch); end
        repeat (20) tick();
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d;
        int          lows;
        write_word(A_LED, 32'h3C);
        write_word(32'h20, 32'h0BAD_F00D);
        @(negedge clk);
        addr     = A_TX;
        memwrite = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            writedata = 32'(i * 17);
            @(posedge clk); #1;
        end
        memwrite = 1'b0;
        repeat (38) tick();
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h0000_0202) begin errors++; $display("[TB] FAIL mid_status_before: got %h expected 00000202", d); end
        pulse_reset();
        checks++; if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL mid_uart_tx: got %b expected 1", uart_tx); end
        checks++; if (leds !== 8'h00) begin errors++; $display("[TB] FAIL mid_leds: got %h expected 00", leds); end
        read_word(A_STATUS, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_status_after: got %h expected 00000000", d); end
        read_word(A_CYCLE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("[TB] FAIL mid_cycle: got %h expected 00000000", d); end
        read_word(32'h20, d);
        checks++; if (d !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL mid_ram_kept: got %h expected 0badf00d", d); end
        read_word(32'h10, d);
        checks++; if (d !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mid_ram_kept2: got %h expected 12345678", d); end
        repeat (200) tick();
        rx_q.delete();
        lows = 0;
        repeat (300) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        checks++; if (lows != 0) begin errors++; $display("[TB] FAIL mid_line_idle: got %0d low cycles expected 0", lows); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("[TB] FAIL mid_no_frames: got %0d frames expected 0", rx_q.size()); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led();
        test_cycle();
        test_uart_single();
        test_overflow();
        test_back_to_back();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory and peripheral subsystem that sits directly downstream of the single-cycle RISC-V core's data memory port (`addr`, `writedata`, `memwrite`, `readdata`). It provides word-addressed RAM plus a small MMIO region: an LED register, a free-running cycle counter, and a UART transmitter with a transmit FIFO. Reads are combinational so the core completes loads in the same cycle. Writes commit on the rising clock edge.

## Interface
Parameters:
- `RAM_WORDS`, default 256: RAM depth in 32-bit words; power of 2.
- `FIFO_DEPTH`, default 4: UART TX FIFO entries; power of 2, at least 2.
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; at least 2.

Ports (reset is `reset`, synchronous, active-high; clock is `clk`):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; has priority over every write.
- `addr`  in  32  byte address from the core.
- `writedata`  in  32  store data.
- `memwrite`  in  1  store strobe, sampled at the rising edge.
- `readdata`  out  32  load data; combinational from `addr`.
- `leds`  out  8  LED register.
- `uart_tx`  out  1  serial output, 8N1, LSB first, idle high; registered.

## Operation
- Decode rule: `addr[31]`=0 selects RAM. `addr[31]`=1 selects MMIO, decoded on `addr[7:2]`. All accesses are whole words, and `addr[1:0]` is ignored.
- RAM:
  - Index is `addr[log2(RAM_WORDS)+1:2]`; higher bits alias.
  - Contents are not reset.
  - A write stores `writedata` at the edge.
- MMIO map, offsets from 0x8000_0000:
  - 0x00 LED: R/W. A write loads `writedata[7:0]`. A read returns `{24'b0, leds}`.
  - 0x04 TXDATA:
    - A write pushes `writedata[7:0]` into the FIFO. The push is accepted iff the FIFO count < FIFO_DEPTH before the edge. Otherwise the byte is dropped and `overflow` is set.
    - A read returns 0.
  - 0x08 STATUS:
    - Read fields: bit0 = FIFO full; bit1 = busy (FSM not IDLE or count≠0); bit2 = `overflow`; bits[15:8] = FIFO count, zero-extended; all other bits 0.
    - A write of any value clears `overflow`. If an overflow occurs on the same edge as the clear, set wins.
  - 0x0C CYCLE: read-only 32-bit counter. It increments every cycle not in reset and wraps from 0xFFFF_FFFF to 0. Writes are ignored.
  - Other MMIO offsets read 0; writes to them are ignored.
- FIFO:
  - Circular buffer with read/write pointers and a count.
  - Push and pop may occur on the same edge; the count is then unchanged.
  - "Full" for push acceptance is the pre-edge state. A pop on the same edge does not make room for a push to a full FIFO.
- UART FSM, with states IDLE, START, DATA, STOP:
  - IDLE: `uart_tx`=1. If count≠0: pop the head into the shift register, clear the bit and cycle counters, and go to START.
  - START: `uart_tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `uart_tx` = shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit count. After 8 bits, go to STOP.
  - STOP: `uart_tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - The FSM spends at least one cycle in IDLE between frames.
- Reset values:
  - `leds`=0, `uart_tx`=1, CYCLE=0.
  - FIFO empty (pointers and count 0), `overflow`=0, FSM IDLE.
  - `readdata` of any MMIO status reads 0 after reset.

## Timing
- Load latency is 0 cycles: `readdata` is valid combinationally in the same cycle that `addr` is driven.
- Store: the effect is visible on reads after the rising edge where `memwrite`=1.
- A TXDATA push at edge N makes count=1 after N. If the FSM is IDLE, the byte is popped at edge N+1, and `uart_tx` goes low from N+1.
- Frame length is 10×CLKS_PER_BIT cycles, start edge to end of stop bit. Back-to-back frames are separated by exactly 1 IDLE cycle.
- CYCLE reads k on the first cycle after reset deasserts, then k+1, and so on, with k=0.
- Reset mid-frame: after the reset edge, `uart_tx`=1 and the FIFO is flushed. LED and CYCLE are cleared. RAM contents are retained.

## Test plan
- RAM: write 0xDEADBEEF to 0x10, read 0x10 → 0xDEADBEEF. Read 0x410 with RAM_WORDS=256 → 0xDEADBEEF (alias). Write 0x12 → same word updated (addr[1:0] ignored).
- LED: write 0x000001A5 to 0x8000_0000 → `leds`=0xA5, readback 0x000000A5. Reset → `leds`=0.
- UART single byte: push 0x55 with CLKS_PER_BIT=16 → `uart_tx` low for cycles 1–16 after the push edge, then bits 1,0,1,0,1,0,1,0 at 16 cycles each, then high for 16 cycles. STATUS bit1=1 during the frame and reads 0x0 one cycle after the stop bit.
- FIFO overflow: 6 pushes on consecutive edges (0x01–0x06) from idle, depth 4 → the first 5 are accepted (one popped at the second edge). The 6th is dropped, and STATUS reads 0x0000_0407 (count 4, overflow, busy, full). 5 frames are emitted in order 0x01–0x05. A STATUS write then clears bit2.
- CYCLE: two reads 10 cycles apart differ by exactly 10. A write to 0x8000_000C does not change the count.
- Reset mid-frame: assert reset 40 cycles into a frame with 2 bytes queued → `uart_tx`=1 after the edge, STATUS=0, no further frames; RAM data written earlier is still readable.
